irq_ctrl: RTL

- Parametrised interrupt controller that replaces the core's single interrupt input with NUM_IRQ prioritised, maskable sources.
- Sits between the external interrupt sources and the program sequencer (PS).
- The PS writes and reads its registers over the bus-connect data path.
- Drives the PS interrupt request with a vector and tracks nested in-service levels.

---
 rtl/irq_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised, maskable, nested interrupt controller that feeds the program sequencer
module irq_ctrl #(
   parameter int NUM_IRQ     = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int VEC_WIDTH   = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IRQ-1:0]    irq_src,
   input  logic                  ps_ic_gie,
   input  logic                  ps_ic_wrt_en,
   input  logic [1:0]            ps_ic_wadd,
   input  logic [1:0]            ps_ic_radd,
   input  logic [DATA_WIDTH-1:0] bc_dt,
   output logic [DATA_WIDTH-1:0] ic_bc_dt,
   output logic                  ic_ps_irq,
   output logic [VEC_WIDTH-1:0]  ic_ps_vec,
   input  logic                  ps_ic_ack,
   input  logic                  ps_ic_rti
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_n;
   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] s, s_d, hw_set, imask, ilat, imode, irptl;
   logic [NUM_IRQ-1:0] elig, below, ack_bit, wdata, ilat_n, irptl_n, rd;
   logic [VEC_WIDTH-1:0] win;
   logic any, ack_ok, unused;
   assign unused  = ^bc_dt;
   assign wdata   = bc_dt[NUM_IRQ-1:0];
   assign s       = sync_q[SYNC_STAGES-1];
   assign hw_set  = (imode & s & ~s_d) | (~imode & s);
   // isolating the lowest in-service bit and subtracting one leaves exactly the
   // strictly-higher-priority indices; with nothing in service it wraps to all ones
   assign below   = (irptl & -irptl) - NUM_IRQ'(1);
   assign elig    = ilat & imask & {NUM_IRQ{ps_ic_gie}} & below;
   assign any     = |elig;
   assign ack_ok  = (state == REQ) && ps_ic_ack;
   assign ack_bit = ack_ok ? NUM_IRQ'(1) << ic_ps_vec : '0;
   // hardware set beats the ack clear, which beats a software write
   assign ilat_n  = hw_set | (~ack_bit & ((ps_ic_wrt_en && ps_ic_wadd == 2'd1) ? wdata : ilat));
   assign irptl_n = (ps_ic_rti ? irptl & (irptl - NUM_IRQ'(1)) : irptl) | ack_bit;
   assign ic_ps_irq = (state == REQ);
   always_comb begin
      win = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (elig[i]) win = VEC_WIDTH'(i);
   end
   always_comb begin
      rd = ps_ic_radd == 2'd0 ? imask : ps_ic_radd == 2'd1 ? ilat : ps_ic_radd == 2'd2 ? imode : irptl;
   end
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (any ? REQ : IDLE) : ((ps_ic_ack || !elig[ic_ps_vec]) ? IDLE : REQ);
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         s_d       <= '0;
         imask     <= '0;
         ilat      <= '0;
         imode     <= '1;
         irptl     <= '0;
         ic_ps_vec <= '0;
         ic_bc_dt  <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         s_d      <= s;
         ilat     <= ilat_n;
         irptl    <= irptl_n;
         imask    <= (ps_ic_wrt_en && ps_ic_wadd == 2'd0) ? wdata : imask;
         imode    <= (ps_ic_wrt_en && ps_ic_wadd == 2'd2) ? wdata : imode;
         ic_bc_dt <= DATA_WIDTH'(rd);
         if (state == IDLE && any) ic_ps_vec <= win;
      end
   end
endmodule
